// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: PC-1 on start, then one PC-2 subkey per accepted handshake,
// in K1..K16 (encrypt) or K16..K1 (decrypt) order.
module des_key_schedule (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key_in,
    input  logic        subkey_ready,
    output logic        subkey_valid,
    output logic [47:0] subkey,
    output logic [3:0]  round_idx,
    output logic        busy,
    output logic        done
);

    typedef enum logic {S_IDLE, S_GEN} state_t;

    // DES tables use 1-based bit numbers with bit 1 at the MSB.
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Bit i set means round i+1 shifts by two; rounds 1, 2, 9 and 16 shift by one.
    localparam logic [15:0] SH_TWO = 16'h7EFC;

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        for (int i = 0; i < 56; i++) begin
            r[6'(55 - i)] = k[6'(64 - PC1_TAB[i])];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        for (int i = 0; i < 48; i++) begin
            r[6'(47 - i)] = cd[6'(56 - PC2_TAB[i])];
        end
        return r;
    endfunction

    function automatic logic [27:0] rot28(input logic [27:0] x, input logic left, input logic two);
        logic [27:0] r;
        if (left) begin
            r = two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
        end else begin
            r = two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
        end
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        dir_q, dir_d;
    logic [47:0] subkey_q, subkey_d;
    logic        done_q, done_d;
    logic [55:0] cd_pc1;
    logic        two;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d  = state_q;
        c_d      = c_q;
        d_d      = d_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        subkey_d = subkey_q;
        done_d   = 1'b0;
        two      = 1'b0;
        cd_pc1   = pc1(key_in);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_GEN;
                    dir_d   = decrypt;
                    cnt_d   = 4'd0;
                    // Decrypt starts at C16/D16, which equals C0/D0 since the shifts sum to 28.
                    c_d     = decrypt ? cd_pc1[55:28] : rot28(cd_pc1[55:28], 1'b1, 1'b0);
                    d_d     = decrypt ? cd_pc1[27:0]  : rot28(cd_pc1[27:0],  1'b1, 1'b0);
                    subkey_d = pc2({c_d, d_d});
                end
            end
            S_GEN: begin
                if (subkey_ready) begin
                    if (cnt_q == 4'd15) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d    = cnt_q + 4'd1;
                        two      = dir_q ? SH_TWO[4'd15 - cnt_q] : SH_TWO[cnt_q + 4'd1];
                        c_d      = rot28(c_q, !dir_q, two);
                        d_d      = rot28(d_q, !dir_q, two);
                        subkey_d = pc2({c_d, d_d});
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            c_q      <= '0;
            d_q      <= '0;
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            subkey_q <= '0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            state_q  <= state_d;
            c_q      <= c_d;
            d_q      <= d_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            subkey_q <= subkey_d;
            done_q   <= done_d;
        end
    end

    assign subkey_valid = (state_q == S_GEN);
    assign busy         = (state_q == S_GEN);
    assign subkey       = subkey_q;
    assign round_idx    = dir_q ? (4'd15 - cnt_q) : cnt_q;
    assign done         = done_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule: table of schedules checked against the published
// subkeys of key 133457799BBCDFF1, plus reset-abort and back-to-back sequences.
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        decrypt;
    logic [63:0] key_in;
    logic        subkey_ready;
    logic        subkey_valid;
    logic [47:0] subkey;
    logic [3:0]  round_idx;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    localparam logic [63:0] KEY = 64'h133457799BBCDFF1;

    // K1..K16 for KEY, hand-converted from the standard worked example.
    localparam logic [47:0] K_TAB [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    typedef struct {
        logic [63:0] key;
        logic        dec;
        logic        zero_exp;
        logic        rand_ready;
        logic        poke_start;
    } vec_t;

    vec_t vecs [6];

    des_key_schedule dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .decrypt      (decrypt),
        .key_in       (key_in),
        .subkey_ready (subkey_ready),
        .subkey_valid (subkey_valid),
        .subkey       (subkey),
        .round_idx    (round_idx),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [47:0] exp_key(input vec_t v, input int n);
        if (v.zero_exp) return 48'h0;
        return K_TAB[v.dec ? 15 - n : n];
    endfunction

    function automatic logic [3:0] exp_idx(input vec_t v, input int n);
        return v.dec ? 4'(15 - n) : 4'(n);
    endfunction

    // Called at a negedge. Runs one schedule; optionally launches the next one in the done cycle.
    task automatic run_sched(input vec_t v, input logic already, input logic chain, input logic chain_dec);
        int   n   = 0;
        int   cyc = 0;
        logic rdy;
        if (!already) begin
            key_in  = v.key;
            decrypt = v.dec;
            start   = 1'b1;
            @(negedge clk);
            start   = 1'b0;
        end
        while (n < 16 && cyc < 400) begin
            check("valid", 64'(subkey_valid), 64'd1);
            check("busy", 64'(busy), 64'd1);
            check("done_in_gen", 64'(done), 64'd0);
            check($sformatf("subkey[%0d]", n), 64'(subkey), 64'(exp_key(v, n)));
            check($sformatf("round_idx[%0d]", n), 64'(round_idx), 64'(exp_idx(v, n)));
            rdy = v.rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (v.poke_start && (cyc == 2 || cyc == 5)) begin
                start   = 1'b1;
                key_in  = ~v.key;
                decrypt = ~v.dec;
            end else begin
                start   = 1'b0;
                key_in  = v.key;
                decrypt = v.dec;
            end
            subkey_ready = rdy;
            @(negedge clk);
            cyc++;
            if (rdy) n++;
        end
        start = 1'b0;
        if (n < 16) check("schedule_timeout", 64'(n), 64'd16);
        if (!v.rand_ready) check("valid_cycles", 64'(cyc), 64'd16);
        check("done_pulse", 64'(done), 64'd1);
        check("valid_after", 64'(subkey_valid), 64'd0);
        check("busy_after", 64'(busy), 64'd0);
        check("subkey_hold", 64'(subkey), 64'(exp_key(v, 15)));
        subkey_ready = 1'b0;
        if (chain) begin
            start   = 1'b1;
            decrypt = chain_dec;
            key_in  = v.key;
        end
        @(negedge clk);
        start = 1'b0;
        check("done_one_cycle", 64'(done), 64'd0);
    endtask

    initial begin
        vecs[0] = '{key: KEY,                          dec: 1'b0, zero_exp: 1'b0, rand_ready: 1'b0, poke_start: 1'b0};
        vecs[1] = '{key: KEY,                          dec: 1'b1, zero_exp: 1'b0, rand_ready: 1'b0, poke_start: 1'b0};
        vecs[2] = '{key: KEY,                          dec: 1'b0, zero_exp: 1'b0, rand_ready: 1'b1, poke_start: 1'b0};
        vecs[3] = '{key: 64'h0,                        dec: 1'b0, zero_exp: 1'b1, rand_ready: 1'b0, poke_start: 1'b0};
        vecs[4] = '{key: KEY ^ 64'h0101010101010101,   dec: 1'b0, zero_exp: 1'b0, rand_ready: 1'b0, poke_start: 1'b0};
        vecs[5] = '{key: KEY,                          dec: 1'b0, zero_exp: 1'b0, rand_ready: 1'b1, poke_start: 1'b1};

        rst_n        = 1'b0;
        start        = 1'b0;
        decrypt      = 1'b0;
        key_in       = '0;
        subkey_ready = 1'b0;
        #1;
        check("rst_valid", 64'(subkey_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_subkey", 64'(subkey), 64'd0);
        check("rst_idx", 64'(round_idx), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_valid", 64'(subkey_valid), 64'd0);

        for (int i = 0; i < 6; i++) begin
            run_sched(vecs[i], 1'b0, 1'b0, 1'b0);
            @(negedge clk);
        end

        // Reset in the middle of a schedule, after five subkeys were consumed.
        key_in       = KEY;
        decrypt      = 1'b0;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        subkey_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("mid_subkey", 64'(subkey), 64'(K_TAB[5]));
        check("mid_idx", 64'(round_idx), 64'd5);
        #3 rst_n = 1'b0;
        #1;
        check("abort_valid", 64'(subkey_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_subkey", 64'(subkey), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", 64'(done), 64'd0);
        end
        subkey_ready = 1'b0;
        rst_n        = 1'b1;
        @(negedge clk);
        check("post_abort_done", 64'(done), 64'd0);
        run_sched(vecs[0], 1'b0, 1'b0, 1'b0);

        // Back-to-back: encrypt, then decrypt started in the done cycle.
        @(negedge clk);
        run_sched(vecs[0], 1'b0, 1'b1, 1'b1);
        run_sched(vecs[1], 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
